// File: rtl/tsc_pkg.sv
// Shared types and widths for the trigger-and-capture controller.
package tsc_pkg;

  localparam int ADC_W = 12;
  localparam int TS_W  = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    STORE = 3'd3,
    GAP   = 3'd4,
    DONE  = 3'd5
  } tsc_state_t;

endpackage

// File: rtl/tsc_trigger_capture_ring_buf.sv
// Capture RAM: one write port, one registered read port.
module tsc_ring_buf
  import tsc_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [ADC_W-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [ADC_W-1:0] o_rd_data
);

  logic [ADC_W-1:0] r_mem [DEPTH];
  logic [ADC_W-1:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Only the output register is reset; the array contents are don't-care.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     r_rd_data <= '0;
    else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/tsc_trigger_capture.sv
// Paces ADC samples into a circular pre-trigger buffer, captures the
// post-trigger window on a threshold crossing, then streams it out oldest-first.
module tsc_trigger_capture
  import tsc_pkg::*;
#(
  parameter int DEPTH       = 32,
  parameter int PRE         = 16,
  parameter int SAMPLE_DIV  = 8,
  parameter int RDY_TIMEOUT = 15
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [ADC_W-1:0] i_threshold,
  output logic             o_adc_req,
  input  logic             i_adc_rdy,
  input  logic [ADC_W-1:0] i_adc_dat,
  output logic             o_busy,
  output logic             o_triggered,
  output logic [TS_W-1:0]  o_timestamp,
  output logic             o_done,
  input  logic             i_rd_req,
  output logic             o_rd_valid,
  output logic [ADC_W-1:0] o_rd_data,
  output logic             o_err,
  output logic [2:0]       o_state
);

  localparam int AW   = $clog2(DEPTH);
  localparam int FW   = AW + 1;
  localparam int POST = DEPTH - PRE;
  localparam int DVW  = $clog2(SAMPLE_DIV) + 1;
  localparam int TOW  = $clog2(RDY_TIMEOUT + 1) + 1;

  localparam logic [2:0] ST_IDLE  = IDLE;
  localparam logic [2:0] ST_REQ   = REQ;
  localparam logic [2:0] ST_WAIT  = WAIT;
  localparam logic [2:0] ST_STORE = STORE;
  localparam logic [2:0] ST_GAP   = GAP;
  localparam logic [2:0] ST_DONE  = DONE;

  logic [2:0]       r_state;
  logic [2:0]       w_next;
  logic [TS_W-1:0]  r_cycle;
  logic             r_rdy_m;
  logic             r_rdy_s;
  logic [ADC_W-1:0] r_thresh;
  logic [ADC_W-1:0] r_sample;
  logic [TOW-1:0]   r_wait_cnt;
  logic [DVW-1:0]   r_div;
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [FW-1:0]    r_fill;
  logic [AW-1:0]    r_post;
  logic [AW-1:0]    r_rd_cnt;
  logic             r_rd_valid;
  logic             r_triggered;
  logic             r_err;
  logic [TS_W-1:0]  r_timestamp;

  logic             w_accept;
  logic             w_timeout;
  logic [FW-1:0]    w_fill_inc;
  logic             w_trig_hit;
  logic             w_rd_fire;

  // ADC handshake: req rises on REQ and stays high through WAIT; a word is
  // taken only when the synchronised rdy is seen with req already high for
  // two cycles, and req drops in STORE to close the transfer.
  assign w_accept   = (r_state == ST_WAIT) && r_rdy_s && (r_wait_cnt != '0);
  assign w_timeout  = (r_state == ST_WAIT) && !w_accept &&
                      (r_wait_cnt == TOW'(RDY_TIMEOUT - 1));
  assign w_fill_inc = (r_fill == FW'(DEPTH)) ? r_fill : r_fill + 1'b1;
  assign w_trig_hit = (r_state == ST_STORE) && !r_triggered &&
                      (w_fill_inc >= FW'(PRE)) && (r_sample > r_thresh);
  assign w_rd_fire  = (r_state == ST_DONE) && i_rd_req;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (i_start) w_next = ST_REQ;
      ST_REQ:   w_next = ST_WAIT;
      ST_WAIT:  if (w_accept || w_timeout) w_next = ST_STORE;
      ST_STORE: begin
        if (w_trig_hit)                             w_next = (POST == 1) ? ST_DONE : ST_GAP;
        else if (r_triggered && r_post == AW'(1))   w_next = ST_DONE;
        else                                        w_next = ST_GAP;
      end
      ST_GAP:   if (r_div == DVW'(SAMPLE_DIV - 1)) w_next = ST_REQ;
      ST_DONE:  if (w_rd_fire && r_rd_cnt == AW'(DEPTH - 1)) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cycle <= '0;
      r_rdy_m <= 1'b0;
      r_rdy_s <= 1'b0;
      r_div   <= '0;
    end else begin
      r_cycle <= r_cycle + 1'b1;
      r_rdy_m <= i_adc_rdy;
      r_rdy_s <= r_rdy_m;
      // Measures the spacing between request starts; saturates once reached.
      if (w_next == ST_REQ)                     r_div <= '0;
      else if (r_div != DVW'(SAMPLE_DIV - 1))   r_div <= r_div + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_thresh    <= '0;
      r_sample    <= '0;
      r_wait_cnt  <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_fill      <= '0;
      r_post      <= '0;
      r_rd_cnt    <= '0;
      r_rd_valid  <= 1'b0;
      r_triggered <= 1'b0;
      r_err       <= 1'b0;
      r_timestamp <= '0;
    end else begin
      r_state    <= w_next;
      r_rd_valid <= w_rd_fire;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_triggered <= 1'b0;
            r_err       <= 1'b0;
            r_fill      <= '0;
            r_thresh    <= i_threshold;
          end
        end
        ST_REQ: r_wait_cnt <= '0;
        ST_WAIT: begin
          r_wait_cnt <= r_wait_cnt + 1'b1;
          if (w_accept) begin
            r_sample <= i_adc_dat;
          end else if (w_timeout) begin
            r_sample <= '0;
            r_err    <= 1'b1;
          end
        end
        ST_STORE: begin
          r_wptr <= r_wptr + 1'b1;
          r_fill <= w_fill_inc;
          if (w_trig_hit) begin
            r_triggered <= 1'b1;
            r_timestamp <= r_cycle;
            r_post      <= AW'(POST - 1);
          end else if (r_triggered) begin
            r_post <= r_post - 1'b1;
          end
          // The slot after the final write holds the oldest sample.
          if (w_next == ST_DONE) begin
            r_rptr   <= r_wptr + 1'b1;
            r_rd_cnt <= '0;
          end
        end
        ST_DONE: begin
          if (w_rd_fire) begin
            r_rptr   <= r_rptr + 1'b1;
            r_rd_cnt <= r_rd_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  tsc_ring_buf #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ring_buf (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_wr_en   (r_state == ST_STORE),
    .i_wr_addr (r_wptr),
    .i_wr_data (r_sample),
    .i_rd_en   (w_rd_fire),
    .i_rd_addr (r_rptr),
    .o_rd_data (o_rd_data)
  );

  assign o_adc_req   = (r_state == ST_REQ) || (r_state == ST_WAIT);
  assign o_busy      = (r_state != ST_IDLE);
  assign o_done      = (r_state == ST_DONE);
  assign o_triggered = r_triggered;
  assign o_timestamp = r_timestamp;
  assign o_rd_valid  = r_rd_valid;
  assign o_err       = r_err;
  assign o_state     = r_state;

endmodule
